// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon permutation output stage.
package ascon_pack;

  // Five 64-bit state words, S0 in the most significant position.
  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } type_state;

  // Operation selected by mode_i when a run is accepted.
  typedef enum logic [1:0] {
    MODE_INIT  = 2'b00,
    MODE_AD    = 2'b01,
    MODE_PT    = 2'b10,
    MODE_FINAL = 2'b11
  } mode_e;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_RUN  = 1'b1
  } fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  // Every run ends on round 11, so a shorter run starts later in the schedule.
  function automatic logic [3:0] round_start(input int rounds);
    return 4'(12 - rounds);
  endfunction

  localparam logic [3:0] ROUND_START_A = round_start(12);
  localparam logic [3:0] ROUND_START_B = round_start(6);

endpackage

// File: rtl/ascon_state_capture_round_counter.sv
// Loadable round index counter; returns to zero after the last round.
module round_counter
  import ascon_pack::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic [3:0] count,
  output logic       last
);

  // Round index: load on accept, advance once per running cycle.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= last ? 4'd0 : count + 4'd1;
    end
  end

  assign last = (count == LAST_ROUND);

endmodule

// File: rtl/ascon_state_capture.sv
// Ascon permutation output stage: state register, round sequencing,
// key XOR at phase end, and ciphertext/tag handshakes.
module ascon_state_capture
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic [1:0]     mode_i,
  input  logic [127:0]   key_i,
  input  logic [63:0]    x0_in_i,
  input  type_state      state_pc_i,
  output type_state      state_o,
  output logic           input_select_o,
  output logic [3:0]     round_o,
  output logic           ready_o,
  output logic           done_o,
  output logic [63:0]    cipher_o,
  output logic           cipher_valid_o,
  input  logic           cipher_ready_i,
  output logic [127:0]   tag_o,
  output logic           tag_valid_o,
  input  logic           tag_ready_i
);

  localparam logic [3:0] START_A = round_start(ROUNDS_A);
  localparam logic [3:0] START_B = round_start(ROUNDS_B);

  fsm_e       fsm_q;
  fsm_e       fsm_d;
  mode_e      mode_q;
  mode_e      mode_in;
  logic       accept;
  logic       run;
  logic       counter_last;
  logic       last_round;
  logic [3:0] start_round;

  assign mode_in     = mode_e'(mode_i);
  assign run         = (fsm_q == FSM_RUN);
  assign ready_o     = (fsm_q == FSM_IDLE) & ~cipher_valid_o & ~tag_valid_o;
  assign accept      = start_i & ready_o;
  assign last_round  = run & counter_last;
  assign start_round = (mode_in == MODE_AD || mode_in == MODE_PT) ? START_B : START_A;

  round_counter u_round_counter (
    .clk        (clock_i),
    .rst        (reset_i),
    .load       (accept),
    .load_value (start_round),
    .enable     (run),
    .count      (round_o),
    .last       (counter_last)
  );

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q <= FSM_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state: IDLE -> RUN on accept, RUN -> IDLE after the last round.
  always_comb begin
    // NOTE: default first so no path leaves fsm_d unassigned and infers a latch.
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE: if (accept)     fsm_d = FSM_RUN;
      FSM_RUN:  if (last_round) fsm_d = FSM_IDLE;
      default:  fsm_d = FSM_IDLE;
    endcase
  end

  // Datapath: capture permutation output, key XOR, output handshakes.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mode_q         <= MODE_INIT;
      state_o        <= '0;
      input_select_o <= 1'b0;
      done_o         <= 1'b0;
      cipher_o       <= '0;
      cipher_valid_o <= 1'b0;
      tag_o          <= '0;
      tag_valid_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (cipher_valid_o && cipher_ready_i) cipher_valid_o <= 1'b0;
      if (tag_valid_o && tag_ready_i)       tag_valid_o    <= 1'b0;

      if (accept) begin
        mode_q         <= mode_in;
        input_select_o <= 1'b1;
        // The post-input-XOR S0 is the ciphertext word in plaintext mode.
        if (mode_in == MODE_PT) begin
          cipher_o       <= x0_in_i;
          cipher_valid_o <= 1'b1;
        end
      end

      if (run) begin
        input_select_o <= 1'b0;
        state_o        <= state_pc_i;
        if (last_round) begin
          done_o <= 1'b1;
          case (mode_q)
            MODE_INIT: begin
              state_o.s3 <= state_pc_i.s3 ^ key_i[127:64];
              state_o.s4 <= state_pc_i.s4 ^ key_i[63:0];
            end
            MODE_FINAL: begin
              tag_o       <= {state_pc_i.s3, state_pc_i.s4} ^ key_i;
              tag_valid_o <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ascon_state_capture.sv
// Directed bench for ascon_state_capture with a toy permutation model.
module tb_ascon_state_capture;
  import ascon_pack::*;

  logic         clock_i;
  logic         reset_i;
  logic         start_i;
  logic [1:0]   mode_i;
  logic [127:0] key_i;
  logic [63:0]  x0_in_i;
  type_state    state_pc_i;
  type_state    state_o;
  logic         input_select_o;
  logic [3:0]   round_o;
  logic         ready_o;
  logic         done_o;
  logic [63:0]  cipher_o;
  logic         cipher_valid_o;
  logic         cipher_ready_i;
  logic [127:0] tag_o;
  logic         tag_valid_o;
  logic         tag_ready_i;

  type_state ext_state;
  type_state pc_in;
  logic [63:0] off;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] KEY_A = 128'h00112233445566778899AABBCCDDEEFF;

  ascon_state_capture dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .key_i          (key_i),
    .x0_in_i        (x0_in_i),
    .state_pc_i     (state_pc_i),
    .state_o        (state_o),
    .input_select_o (input_select_o),
    .round_o        (round_o),
    .ready_o        (ready_o),
    .done_o         (done_o),
    .cipher_o       (cipher_o),
    .cipher_valid_o (cipher_valid_o),
    .cipher_ready_i (cipher_ready_i),
    .tag_o          (tag_o),
    .tag_valid_o    (tag_valid_o),
    .tag_ready_i    (tag_ready_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Toy permutation: +1 per word per round; on the first round (external
  // input) word i also gains its index i. From all-zero, 12 rounds give 12..16.
  always_comb begin
    pc_in = input_select_o ? ext_state : state_o;
    off   = input_select_o ? 64'd1 : 64'd0;
    state_pc_i.s0 = pc_in.s0 + 64'd1;
    state_pc_i.s1 = pc_in.s1 + 64'd1 + off;
    state_pc_i.s2 = pc_in.s2 + 64'd1 + 64'd2 * off;
    state_pc_i.s3 = pc_in.s3 + 64'd1 + 64'd3 * off;
    state_pc_i.s4 = pc_in.s4 + 64'd1 + 64'd4 * off;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; key_i = '0; x0_in_i = '0;
    ext_state = '0; cipher_ready_i = 1'b0; tag_ready_i = 1'b0;
    step(); step();

    // Reset values
    check("rst_state", state_o, 128'd0);
    check("rst_round", round_o, 128'd0);
    check("rst_sel", input_select_o, 128'd0);
    check("rst_done", done_o, 128'd0);
    check("rst_cipher", cipher_o, 128'd0);
    check("rst_cvalid", cipher_valid_o, 128'd0);
    check("rst_tag", tag_o, 128'd0);
    check("rst_tvalid", tag_valid_o, 128'd0);
    check("rst_ready", ready_o, 128'd1);
    reset_i = 1'b0;
    step();

    // Init p12 with key XOR
    key_i = KEY_A; mode_i = 2'b00; ext_state = '0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("init_sel_first", input_select_o, 128'd1);
    check("init_round_first", round_o, 128'd0);
    check("init_ready_busy", ready_o, 128'd0);
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("init_done_c%0d", n), done_o, (n == 12) ? 128'd1 : 128'd0);
      check($sformatf("init_sel_c%0d", n), input_select_o, 128'd0);
    end
    check("init_s0", state_o.s0, 128'd12);
    check("init_s1", state_o.s1, 128'd13);
    check("init_s2", state_o.s2, 128'd14);
    check("init_s3", state_o.s3, 128'(64'd15 ^ 64'h0011223344556677));
    check("init_s4", state_o.s4, 128'(64'd16 ^ 64'h8899AABBCCDDEEFF));
    check("init_round_end", round_o, 128'd0);
    check("init_ready_end", ready_o, 128'd1);
    check("init_tvalid", tag_valid_o, 128'd0);
    step();
    check("init_done_pulse", done_o, 128'd0);

    // Plaintext p6 with stalled cipher consumer
    x0_in_i = 64'hDEADBEEF00000001; mode_i = 2'b10; start_i = 1'b1;
    step();
    start_i = 1'b0;
    x0_in_i = 64'h0;
    check("pt_cvalid", cipher_valid_o, 128'd1);
    check("pt_cipher", cipher_o, 128'hDEADBEEF00000001);
    check("pt_round_first", round_o, 128'd6);
    for (int n = 1; n <= 6; n++) begin
      step();
      check($sformatf("pt_done_c%0d", n), done_o, (n == 6) ? 128'd1 : 128'd0);
    end
    step(); step();
    check("pt_ready_held", ready_o, 128'd0);
    check("pt_cvalid_held", cipher_valid_o, 128'd1);
    check("pt_cipher_held", cipher_o, 128'hDEADBEEF00000001);
    cipher_ready_i = 1'b1;
    step();
    cipher_ready_i = 1'b0;
    check("pt_cvalid_drop", cipher_valid_o, 128'd0);
    check("pt_ready_rise", ready_o, 128'd1);

    // Assoc data p6; start held and ready inputs high while valids are low
    ext_state = '{s0: 64'd100, s1: 64'd200, s2: 64'd300, s3: 64'd400, s4: 64'd500};
    mode_i = 2'b01; cipher_ready_i = 1'b1; tag_ready_i = 1'b1; start_i = 1'b1;
    step();
    mode_i = 2'b11;
    check("ad_round_first", round_o, 128'd6);
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("ad_round_c%0d", n), round_o, 128'(6 + n));
      check($sformatf("ad_cvalid_c%0d", n), cipher_valid_o, 128'd0);
      check($sformatf("ad_tvalid_c%0d", n), tag_valid_o, 128'd0);
      check($sformatf("ad_done_c%0d", n), done_o, 128'd0);
    end
    start_i = 1'b0;
    step();
    check("ad_round_end", round_o, 128'd0);
    check("ad_done", done_o, 128'd1);
    check("ad_state", state_o, {64'd106, 64'd207, 64'd308, 64'd409, 64'd510});
    step();
    check("ad_done_pulse", done_o, 128'd0);
    check("ad_tvalid", tag_valid_o, 128'd0);
    check("ad_cvalid", cipher_valid_o, 128'd0);
    check("ad_ready", ready_o, 128'd1);
    cipher_ready_i = 1'b0; tag_ready_i = 1'b0;

    // Finalisation p12, all-ones key
    key_i = '1; mode_i = 2'b11; ext_state = '0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("fin_done_c%0d", n), done_o, (n == 12) ? 128'd1 : 128'd0);
    end
    check("fin_tvalid", tag_valid_o, 128'd1);
    check("fin_tag", tag_o, {~64'd15, ~64'd16});
    check("fin_s3", state_o.s3, 128'd15);
    check("fin_s4", state_o.s4, 128'd16);
    step();
    check("fin_tvalid_held", tag_valid_o, 128'd1);
    check("fin_tag_held", tag_o, {~64'd15, ~64'd16});
    check("fin_ready_busy", ready_o, 128'd0);
    mode_i = 2'b00; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("fin_ign_round", round_o, 128'd0);
    check("fin_ign_sel", input_select_o, 128'd0);
    check("fin_ign_s0", state_o.s0, 128'd12);
    check("fin_ign_tvalid", tag_valid_o, 128'd1);
    tag_ready_i = 1'b1;
    step();
    tag_ready_i = 1'b0;
    check("fin_tvalid_drop", tag_valid_o, 128'd0);
    check("fin_ready_rise", ready_o, 128'd1);

    // Reset during round 3 of p12, then a normal p6 run
    key_i = KEY_A; mode_i = 2'b00; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step(); step();
    check("abort_round3", round_o, 128'd3);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("abort_state", state_o, 128'd0);
    check("abort_round", round_o, 128'd0);
    check("abort_sel", input_select_o, 128'd0);
    check("abort_done", done_o, 128'd0);
    check("abort_cvalid", cipher_valid_o, 128'd0);
    check("abort_tvalid", tag_valid_o, 128'd0);
    check("abort_ready", ready_o, 128'd1);
    step();
    check("abort_no_done", done_o, 128'd0);
    check("abort_idle_round", round_o, 128'd0);
    mode_i = 2'b01; ext_state = '0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("restart_round", round_o, 128'd6);
    check("restart_sel", input_select_o, 128'd1);
    for (int n = 1; n <= 6; n++) begin
      step();
      check($sformatf("restart_done_c%0d", n), done_o, (n == 6) ? 128'd1 : 128'd0);
    end
    check("restart_s0", state_o.s0, 128'd6);
    check("restart_s4", state_o.s4, 128'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
